// File: rtl/riscv_issue_scoreboard.sv
// riscv_issue_scoreboard: issue-stage hazard controller.
// Tracks one busy bit per architectural register for every in-flight
// instruction. It holds decoded instructions on RAW/WAW hazards, unit stalls,
// CSR serialisation and the muldiv outstanding limit.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN. When this macro is defined,
// writebacks in the current cycle mask the matching busy bits for the hazard
// and DRAIN-exit checks.
module riscv_issue_scoreboard #(
  parameter int MULDIV_DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [1:0]  issue_unit_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic        issue_writes_rd_i,
  input  logic        issue_uses_ra_i,
  input  logic        issue_uses_rb_i,
  input  logic        exec_stall_i,
  input  logic        lsu_stall_i,
  input  logic        csr_stall_i,
  input  logic        writeback_exec_valid_i,
  input  logic [4:0]  writeback_exec_idx_i,
  input  logic        writeback_mem_valid_i,
  input  logic [4:0]  writeback_mem_idx_i,
  input  logic        writeback_csr_valid_i,
  input  logic [4:0]  writeback_csr_idx_i,
  input  logic        writeback_muldiv_valid_i,
  input  logic [4:0]  writeback_muldiv_idx_i,
  output logic        issue_accept_o,
  output logic [31:0] busy_o,
  output logic [1:0]  muldiv_pending_o,
  output logic        csr_serialising_o,
  output logic        spurious_wb_o
);

  localparam logic [1:0] LP_MD_MAX = 2'(MULDIV_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RSVD  = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_busy;
  logic [1:0]  r_md_pend;
  logic        r_spurious;
  logic        r_csr_nowb;

  logic [31:0] w_wb_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_chk;
  logic        w_hazard;
  logic        w_unit_stall;
  logic        w_is_csr;
  logic        w_is_md;
  logic        w_md_full;
  logic        w_clean_reg;
  logic        w_clean_chk;
  logic        w_fsm_ok;
  logic        w_accept;
  logic        w_md_inc;
  logic        w_md_dec;

  // Collect registers written back this cycle (x0 writes are ignored)
  always_comb begin
    w_wb_mask = '0;
    if (writeback_exec_valid_i   && (writeback_exec_idx_i   != 5'd0)) w_wb_mask[writeback_exec_idx_i]   = 1'b1;
    if (writeback_mem_valid_i    && (writeback_mem_idx_i    != 5'd0)) w_wb_mask[writeback_mem_idx_i]    = 1'b1;
    if (writeback_csr_valid_i    && (writeback_csr_idx_i    != 5'd0)) w_wb_mask[writeback_csr_idx_i]    = 1'b1;
    if (writeback_muldiv_valid_i && (writeback_muldiv_idx_i != 5'd0)) w_wb_mask[writeback_muldiv_idx_i] = 1'b1;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A register completing this cycle no longer blocks a dependent issue
  assign w_busy_chk = r_busy & ~w_wb_mask;
`else
  assign w_busy_chk = r_busy;
`endif

  assign w_hazard = (issue_uses_ra_i   && (issue_ra_idx_i != 5'd0) && w_busy_chk[issue_ra_idx_i]) ||
                    (issue_uses_rb_i   && (issue_rb_idx_i != 5'd0) && w_busy_chk[issue_rb_idx_i]) ||
                    (issue_writes_rd_i && (issue_rd_idx_i != 5'd0) && w_busy_chk[issue_rd_idx_i]);

  // Map the target unit onto its downstream stall
  always_comb begin
    w_unit_stall = 1'b0;
    case (issue_unit_i)
      2'd0:    w_unit_stall = exec_stall_i;
      2'd1:    w_unit_stall = lsu_stall_i;
      2'd2:    w_unit_stall = csr_stall_i;
      default: w_unit_stall = exec_stall_i;
    endcase
  end

  assign w_is_csr    = (issue_unit_i == 2'd2);
  assign w_is_md     = (issue_unit_i == 2'd3);
  assign w_md_full   = (r_md_pend >= LP_MD_MAX);
  assign w_clean_reg = (r_busy == '0) && (r_md_pend == 2'd0);
  assign w_clean_chk = (w_busy_chk == '0) && (r_md_pend == 2'd0);

  // CSR serialisation gate: CSRs need a clean scoreboard, DRAIN/WAIT hold everything else
  always_comb begin
    w_fsm_ok = 1'b0;
    case (r_state)
      ST_IDLE:  w_fsm_ok = !w_is_csr || w_clean_reg;
      ST_DRAIN: w_fsm_ok = w_is_csr && w_clean_chk;
      default:  w_fsm_ok = 1'b0;
    endcase
  end

  // rst_i gates the accept so nothing issues while reset is held
  assign w_accept = rst_i && issue_valid_i && !w_hazard && !w_unit_stall && w_fsm_ok &&
                    (!w_is_md || !w_md_full);

  assign w_set_mask = (w_accept && issue_writes_rd_i && (issue_rd_idx_i != 5'd0))
                      ? (32'd1 << issue_rd_idx_i) : 32'd0;

  assign w_md_inc = w_accept && w_is_md;
  assign w_md_dec = writeback_muldiv_valid_i;

  // Busy vector: writebacks clear, accepts set, set wins on the same register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_wb_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  // Sticky flag for a writeback to a register that was not in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_spurious <= 1'b0;
    end else if ((w_wb_mask & ~r_busy) != '0) begin
      r_spurious <= 1'b1;
    end
  end

  // Outstanding muldiv count, saturating at 0 and MULDIV_DEPTH
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_md_pend <= 2'd0;
    end else begin
      case ({w_md_inc, w_md_dec})
        2'b10: if (r_md_pend < LP_MD_MAX) r_md_pend <= r_md_pend + 2'd1;
        2'b01: if (r_md_pend != 2'd0)     r_md_pend <= r_md_pend - 2'd1;
        default: r_md_pend <= r_md_pend;
      endcase
    end
  end

  // CSR serialisation FSM: drain in-flight work, issue the CSR, wait for its writeback
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_csr_nowb <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (issue_valid_i && w_is_csr) begin
            if (!w_clean_reg) begin
              r_state <= ST_DRAIN;
            end else if (w_accept) begin
              r_state    <= ST_WAIT;
              r_csr_nowb <= !(issue_writes_rd_i && (issue_rd_idx_i != 5'd0));
            end
          end
        end
        ST_DRAIN: begin
          if (!issue_valid_i) begin
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_state    <= ST_WAIT;
            r_csr_nowb <= !(issue_writes_rd_i && (issue_rd_idx_i != 5'd0));
          end
        end
        ST_WAIT: begin
          // A CSR without a register result has nothing to wait for
          if (r_csr_nowb || writeback_csr_valid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign issue_accept_o    = w_accept;
  assign busy_o            = r_busy;
  assign muldiv_pending_o  = r_md_pend;
  assign csr_serialising_o = (r_state != ST_IDLE);
  assign spurious_wb_o     = r_spurious;

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
// Directed bench for riscv_issue_scoreboard (MULDIV_DEPTH=2).
// Expected accept values are queued as each step is driven and popped when
// the step's output is sampled.
module tb_riscv_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  unit = 2'd0;
  logic [4:0]  rd = 5'd0, ra = 5'd0, rb = 5'd0;
  logic        wrd = 1'b0, ura = 1'b0, urb = 1'b0;
  logic        ex_st = 1'b0, ls_st = 1'b0, cs_st = 1'b0;
  logic        wbv_ex = 1'b0, wbv_mem = 1'b0, wbv_csr = 1'b0, wbv_md = 1'b0;
  logic [4:0]  wbi_ex = 5'd0, wbi_mem = 5'd0, wbi_csr = 5'd0, wbi_md = 5'd0;

  logic        accept;
  logic [31:0] busy;
  logic [1:0]  pend;
  logic        ser;
  logic        spur;

  int total = 0;
  int bad   = 0;
  logic q_exp[$];

  always #5 clk = ~clk;

  riscv_issue_scoreboard #(.MULDIV_DEPTH(2)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst_n),
    .issue_valid_i            (valid),
    .issue_unit_i             (unit),
    .issue_rd_idx_i           (rd),
    .issue_ra_idx_i           (ra),
    .issue_rb_idx_i           (rb),
    .issue_writes_rd_i        (wrd),
    .issue_uses_ra_i          (ura),
    .issue_uses_rb_i          (urb),
    .exec_stall_i             (ex_st),
    .lsu_stall_i              (ls_st),
    .csr_stall_i              (cs_st),
    .writeback_exec_valid_i   (wbv_ex),
    .writeback_exec_idx_i     (wbi_ex),
    .writeback_mem_valid_i    (wbv_mem),
    .writeback_mem_idx_i      (wbi_mem),
    .writeback_csr_valid_i    (wbv_csr),
    .writeback_csr_idx_i      (wbi_csr),
    .writeback_muldiv_valid_i (wbv_md),
    .writeback_muldiv_idx_i   (wbi_md),
    .issue_accept_o           (accept),
    .busy_o                   (busy),
    .muldiv_pending_o         (pend),
    .csr_serialising_o        (ser),
    .spurious_wb_o            (spur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic v, input logic [1:0] u, input logic [4:0] d, a, b,
                     input logic w, ua, ub);
    valid = v; unit = u; rd = d; ra = a; rb = b; wrd = w; ura = ua; urb = ub;
  endtask

  task automatic wb(input int port, input logic [4:0] idx);
    case (port)
      0: begin wbv_ex  = 1'b1; wbi_ex  = idx; end
      1: begin wbv_mem = 1'b1; wbi_mem = idx; end
      2: begin wbv_csr = 1'b1; wbi_csr = idx; end
      default: begin wbv_md = 1'b1; wbi_md = idx; end
    endcase
  endtask

  task automatic clr_wb();
    wbv_ex = 1'b0; wbv_mem = 1'b0; wbv_csr = 1'b0; wbv_md = 1'b0;
    wbi_ex = 5'd0; wbi_mem = 5'd0; wbi_csr = 5'd0; wbi_md = 5'd0;
  endtask

  task automatic idle_in();
    iss(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_st = 1'b0; ls_st = 1'b0; cs_st = 1'b0;
  endtask

  // One clock step: queue the expected accept, sample mid-cycle, advance past the edge
  task automatic cyc(input logic exp_acc, input string tag);
    logic e;
    q_exp.push_back(exp_acc);
    @(negedge clk);
    e = q_exp.pop_front();
    chk(tag, accept, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with a clean CSR presented to show accept is gated
    iss(1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_busy", busy, 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_ser",  ser, 32'd0);
    chk("rst_spur", spur, 32'd0);
    chk("rst_acc",  accept, 32'd0);
    idle_in();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // RAW hazard on x5
    iss(1'b1, 2'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, "raw_prod");
    chk("raw_busy5", busy, 32'h0000_0020);
    iss(1'b1, 2'd0, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, "raw_held");
    wb(0, 5'd5);
`ifdef SCOREBOARD_WB_BYPASS_EN
    cyc(1'b1, "raw_bypass");
    clr_wb();
`else
    cyc(1'b0, "raw_wb_cycle");
    clr_wb();
    cyc(1'b1, "raw_after_wb");
`endif
    chk("raw_busy1", busy, 32'h0000_0002);
    idle_in();
    wb(0, 5'd1);
    cyc(1'b0, "raw_idle");
    clr_wb();
    chk("raw_clear", busy, 32'd0);

    // WAW hazard on x7, then x0 destinations
    iss(1'b1, 2'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, "waw_first");
    cyc(1'b0, "waw_second");
    chk("waw_busy7", busy, 32'h0000_0080);
    idle_in();
    wb(1, 5'd7);
    cyc(1'b0, "waw_idle");
    clr_wb();
    chk("waw_clear", busy, 32'd0);
    iss(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, "x0_issue");
      chk("x0_busy", busy, 32'd0);
    end

    // Unit stalls
    ex_st = 1'b1;
    iss(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, "exec_stalled");
    iss(1'b1, 2'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, "lsu_free");
    idle_in();

    // Muldiv depth 2
    iss(1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, "md1");        chk("md_pend1", pend, 32'd1);
    cyc(1'b1, "md2");        chk("md_pend2", pend, 32'd2);
    cyc(1'b0, "md3_held");   chk("md_pend2h", pend, 32'd2);
    wb(3, 5'd0);
    cyc(1'b0, "md3_wb");     chk("md_pend1w", pend, 32'd1);
    clr_wb();
    cyc(1'b1, "md3_go");     chk("md_pend2g", pend, 32'd2);
    idle_in();
    wb(3, 5'd0);
    cyc(1'b0, "md_drain1");  chk("md_pend_d1", pend, 32'd1);
    cyc(1'b0, "md_drain0");  chk("md_pend_d0", pend, 32'd0);
    cyc(1'b0, "md_sat");     chk("md_pend_sat", pend, 32'd0);
    clr_wb();
    chk("md_no_spur", spur, 32'd0);

    // CSR serialisation behind busy x3
    iss(1'b1, 2'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, "csr_prod3");
    iss(1'b1, 2'd2, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, "csr_dirty");  chk("csr_ser_drain", ser, 32'd1);
    cyc(1'b0, "csr_drain");  chk("csr_ser_drain2", ser, 32'd1);
    wb(0, 5'd3);
`ifdef SCOREBOARD_WB_BYPASS_EN
    cyc(1'b1, "csr_drain_exit");
    clr_wb();
`else
    cyc(1'b0, "csr_drain_wbcyc");
    clr_wb();
    cyc(1'b1, "csr_drain_exit");
`endif
    chk("csr_busy4", busy, 32'h0000_0010);
    chk("csr_ser_wait", ser, 32'd1);
    iss(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, "wait_held1");
    cyc(1'b0, "wait_held2");
    wb(2, 5'd4);
    cyc(1'b0, "wait_wb");
    clr_wb();
    chk("csr_ser_idle", ser, 32'd0);
    chk("csr_busy_clr", busy, 32'd0);
    cyc(1'b1, "after_csr");

    // CSR without a register result leaves WAIT after one cycle
    iss(1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, "csr_nord");   chk("nord_ser1", ser, 32'd1);
    iss(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, "nord_wait");  chk("nord_ser0", ser, 32'd0);
    cyc(1'b1, "nord_after");

    // Spurious writeback to idle x12 is sticky
    idle_in();
    chk("spur_before", spur, 32'd0);
    wb(1, 5'd12);
    cyc(1'b0, "spur_wb");
    clr_wb();
    chk("spur_set", spur, 32'd1);
    cyc(1'b0, "spur_hold");
    chk("spur_sticky", spur, 32'd1);

    // Same-edge set and clear on x9: set wins
    iss(1'b1, 2'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    wb(0, 5'd9);
    cyc(1'b1, "setclr");
    clr_wb();
    idle_in();
    chk("setclr_busy9", busy, 32'h0000_0200);

    // Asynchronous reset in the middle of DRAIN
    iss(1'b1, 2'd2, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, "rst_dirty");
    chk("rst_drain_ser", ser, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_pend", pend, 32'd0);
    chk("mid_rst_ser",  ser, 32'd0);
    chk("mid_rst_spur", spur, 32'd0);
    chk("mid_rst_acc",  accept, 32'd0);
    idle_in();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ser", ser, 32'd0);
    iss(1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, "post_rst_csr");
    idle_in();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
